// File: rtl/mux_nway_pkg.sv
// Shared definitions for the N-way streaming multiplexer family.
package mux_nway_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width that stays at least one bit wide, even for tiny channel counts.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above the last grant and wraps.
module rr_arbiter
  import mux_nway_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = SEL_W'((int'(last) + k) % int'(N));
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nway_arb.sv
// Registered N-way mux with valid/ready handshakes, fixed or round-robin channel selection.
module mux_nway_arb
  import mux_nway_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SEL_W-1:0] last;
  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     fixed_gnt;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             any_gnt;
  logic             load;
  logic [WIDTH-1:0] mux_data;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_rr (
    .req     (in_valid),
    .last    (last),
    .en      (mode == MODE_RR),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel yields no grant.
  always_comb begin
    fixed_gnt = '0;
    if (int'(sel) < int'(N)) fixed_gnt[sel] = in_valid[sel];
  end

  always_comb begin
    load     = !out_valid || out_ready;
    gnt      = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
    any_gnt  = |gnt;
    in_ready = reset ? '0 : (gnt & {N{load}});
  end

  // One-hot grant drives the flattened data mux.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i]) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SEL_W'(N - 1);
    end else if (load) begin
      if (any_gnt) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_chan  <= gnt_idx;
        last      <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nway_arb.sv
// Directed self-checking bench for mux_nway_arb with WIDTH=4, N=4.
module tb_mux_nway_arb;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N     = 4;
  localparam int unsigned SEL_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_valid;
  logic             out_ready;

  int n_cmp = 0;
  int n_err = 0;

  mux_nway_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] d, input logic [1:0] c, input logic v);
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".chan"}, 32'(out_chan), 32'(c));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] rr_seq [5];
    logic [1:0] sw_seq [3];
    logic [3:0] sw_dat [3];
    rr_seq = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    sw_seq = '{2'd2, 2'd3, 2'd0};
    sw_dat = '{4'hC, 4'hD, 4'hA};

    // Reset state, with requests pending that must not be accepted
    reset = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    in_data = 16'hDCBA; out_ready = 1'b1;
    tick(); tick();
    chk_out("reset", 4'h0, 2'd0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);

    // 1: fixed mode, sel=2 then sel=3
    reset = 1'b0; sel = 2'd2;
    #1 chk("fixed.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("fixed.sel2", 4'hC, 2'd2, 1'b1);
    sel = 2'd3;
    tick();
    chk_out("fixed.sel3", 4'hD, 2'd3, 1'b1);

    // 2: round robin straight after reset, then with channel 1 idle
    reset = 1'b1; tick();
    reset = 1'b0; mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr.chan", 32'(out_chan), 32'(i % 4));
      chk("rr.valid", 32'(out_valid), 32'h1);
    end
    in_valid = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr.skip1", 32'(out_chan), 32'(rr_seq[i]));
    end

    // 3: backpressure holds 4'hA, release follows with no bubble
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    tick();
    chk_out("bp.load", 4'hA, 2'd0, 1'b1);
    out_ready = 1'b0; in_data = 16'hDCB5;
    #1 chk("bp.in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("bp.hold", 4'hA, 2'd0, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("bp.next", 4'h5, 2'd0, 1'b1);

    // 4: sparse input and a single pulse on channel 3
    in_valid = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sparse.valid", 32'(out_valid), 32'h0);
    end
    mode = 1'b1; in_valid = 4'b1000; in_data = 16'h7000;
    tick();
    chk_out("pulse", 4'h7, 2'd3, 1'b1);
    in_valid = 4'h0;
    tick();
    chk_out("pulse.after", 4'h7, 2'd3, 1'b0);

    // 5: fixed sel=1 twice, then round robin resumes after 1
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; in_data = 16'hDCBA;
    tick();
    chk_out("sw.fix0", 4'hB, 2'd1, 1'b1);
    tick();
    chk_out("sw.fix1", 4'hB, 2'd1, 1'b1);
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("sw.rr", sw_dat[i], sw_seq[i], 1'b1);
    end

    // 6: reset during a stall discards the word, RR restarts at channel 0
    tick();
    chk_out("rst.pre", 4'hB, 2'd1, 1'b1);
    out_ready = 1'b0;
    tick();
    chk_out("rst.stall", 4'hB, 2'd1, 1'b1);
    reset = 1'b1;
    tick();
    chk_out("rst.mid", 4'h0, 2'd0, 1'b0);
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("rst.first_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("rst.first", 4'hA, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
